// File: rtl/half_fp_pkg.sv
// rtl/half_fp_pkg.sv - IEEE half-precision constants, FSM state type and flag bit indices
package half_fp_pkg;

  localparam int HALF_BIAS    = 15;
  localparam int HALF_EXP_MAX = 31;

  localparam logic [15:0] HALF_INF  = 16'h7C00;
  localparam logic [15:0] HALF_MAXF = 16'h7BFF;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/half_rne_round.sv
// rtl/half_rne_round.sv - round-to-nearest-even of a normalized 1.20 significand to 11 bits
module half_rne_round (
  input  logic              [20:0] mant_i,
  input  logic                     sticky_i,
  input  logic signed       [8:0]  exp_i,
  output logic              [9:0]  frac_o,
  output logic signed       [8:0]  exp_o,
  output logic                     inexact_o
);

  logic        guard;
  logic        sticky_all;
  logic        round_up;
  logic [11:0] sum;

  assign guard      = mant_i[9];
  assign sticky_all = (|mant_i[8:0]) | sticky_i;
  assign round_up   = guard & (sticky_all | mant_i[10]);
  assign sum        = {1'b0, mant_i[20:10]} + {11'b0, round_up};
  assign inexact_o  = guard | sticky_all;

  // A carry out of the 11-bit significand leaves exactly 1.0, so the fraction is zero.
  assign frac_o = sum[11] ? 10'b0 : sum[9:0];
  assign exp_o  = sum[11] ? exp_i + 9'sd1 : exp_i;

endmodule

// File: rtl/half_norm_round.sv
// rtl/half_norm_round.sv - normalize and RNE-round a raw half-precision product; HALF_NR_SAT_EN saturates overflow to max finite
module half_norm_round
  import half_fp_pkg::*;
#(
  parameter int SHIFT_LIMIT = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [21:0] in_mant,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_flags
);

  localparam int CNT_W = $clog2(SHIFT_LIMIT + 1);
  localparam logic signed [8:0] EXP_MAX_S = 9'(HALF_EXP_MAX);

  state_e                  state_q;
  logic                    sign_q;
  logic                    sticky_q;
  logic signed [8:0]       exp_q;
  logic        [21:0]      mant_q;
  logic        [CNT_W-1:0] shift_cnt_q;
  logic                    out_valid_q;
  logic        [15:0]      out_result_q;
  logic        [2:0]       out_flags_q;

  logic        [9:0]       rnd_frac;
  logic signed [8:0]       rnd_exp;
  logic                    rnd_inexact;
  logic        [15:0]      pack_result;
  logic        [2:0]       pack_flags;

  half_rne_round u_rne (
    .mant_i    (mant_q[20:0]),
    .sticky_i  (sticky_q),
    .exp_i     (exp_q),
    .frac_o    (rnd_frac),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    pack_result           = {sign_q, rnd_exp[4:0], rnd_frac};
    pack_flags            = '0;
    pack_flags[FLAG_INX]  = rnd_inexact;
    if (rnd_exp >= EXP_MAX_S) begin
`ifdef HALF_NR_SAT_EN
      pack_result = {sign_q, HALF_MAXF[14:0]};
`else
      pack_result = {sign_q, HALF_INF[14:0]};
`endif
      pack_flags[FLAG_OVF] = 1'b1;
      pack_flags[FLAG_INX] = 1'b1;
    end else if (rnd_exp <= 9'sd0) begin
      // No subnormal outputs: anything below the normal range flushes to signed zero.
      pack_result          = {sign_q, 15'b0};
      pack_flags[FLAG_UNF] = 1'b1;
      pack_flags[FLAG_INX] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sign_q       <= 1'b0;
      sticky_q     <= 1'b0;
      exp_q        <= '0;
      mant_q       <= '0;
      shift_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q      <= in_sign;
            exp_q       <= {{2{in_exp[6]}}, in_exp};
            mant_q      <= in_mant;
            sticky_q    <= 1'b0;
            shift_cnt_q <= '0;
            if (in_zero || (in_mant == '0)) begin
              out_result_q <= {in_sign, 15'b0};
              out_flags_q  <= '0;
              out_valid_q  <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (mant_q[21]) begin
            mant_q   <= {1'b0, mant_q[21:1]};
            sticky_q <= sticky_q | mant_q[0];
            exp_q    <= exp_q + 9'sd1;
            state_q  <= ST_ROUND;
          end else if (mant_q[20] || (shift_cnt_q == CNT_W'(SHIFT_LIMIT))) begin
            state_q <= ST_ROUND;
          end else begin
            mant_q      <= {mant_q[20:0], 1'b0};
            exp_q       <= exp_q - 9'sd1;
            shift_cnt_q <= shift_cnt_q + CNT_W'(1);
          end
        end
        ST_ROUND: begin
          out_result_q <= pack_result;
          out_flags_q  <= pack_flags;
          out_valid_q  <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready   = rst_n & (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_half_norm_round.sv
// tb/tb_half_norm_round.sv - directed and randomized checks of half_norm_round against an arithmetic reference
module tb_half_norm_round;
  import half_fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic [21:0] in_mant;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  half_norm_round #(.SHIFT_LIMIT(21)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rounds the exact value m * 2^(e-35) to half precision with plain integer arithmetic.
  function automatic void ref_model(input logic s, input logic [6:0] e7, input logic [21:0] m,
                                    input logic z, output logic [15:0] res,
                                    output logic [2:0] fl, output int lat);
    int      p, sh, e;
    longint  kept, rem, half;
    bit      inexact;
    if (z || m == 22'd0) begin
      res = {s, 15'b0};
      fl  = 3'b000;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 22; i++) if (m[i]) p = i;
    e  = $signed(e7);
    e  = e + (p - 20);
    sh = p - 10;
    if (sh > 0) begin
      kept = longint'(m) >> sh;
      rem  = longint'(m) & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
    end else begin
      kept = longint'(m) << (-sh);
      rem  = 0;
      half = 1;
    end
    inexact = (rem != 0);
    if (rem > half || (rem == half && kept[0])) kept++;
    if (kept == 2048) begin
      kept = 1024;
      e++;
    end
    lat = (p >= 20) ? 3 : 3 + (20 - p);
    if (e >= 31) begin
`ifdef HALF_NR_SAT_EN
      res = {s, 15'h7BFF};
`else
      res = {s, 15'h7C00};
`endif
      fl = 3'b101;
    end else if (e <= 0) begin
      res = {s, 15'b0};
      fl  = 3'b011;
    end else begin
      res = {s, 5'(e), 10'(kept - 1024)};
      fl  = {2'b00, inexact};
    end
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [6:0] e7,
                        input logic [21:0] m, input logic z, input int hold);
    logic [15:0] er;
    logic [2:0]  ef;
    int          el, lat;
    ref_model(s, e7, m, z, er, ef, el);
    @(negedge clk);
    in_sign  = s;
    in_exp   = e7;
    in_mant  = m;
    in_zero  = z;
    in_valid = 1'b1;
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(el));
    check({tag, ":out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ":result"}, 32'(out_result), 32'(er));
    check({tag, ":flags"}, 32'(out_flags), 32'(ef));
    check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_result"}, 32'(out_result), 32'(er));
      check({tag, ":hold_flags"}, 32'(out_flags), 32'(ef));
      check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ":in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic        rs, rz;
    logic [6:0]  re;
    logic [21:0] rm, mask, lead;
    int          p;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:out_result", 32'(out_result), 32'd0);
    check("rst:out_flags", 32'(out_flags), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sq1p5", 1'b0, 7'd15, 22'h240000, 1'b0, 0);
    run_op("zero", 1'b1, 7'd9, 22'h123456, 1'b1, 0);
    run_op("mant0", 1'b0, 7'd20, 22'h000000, 1'b0, 0);
    run_op("shift2", 1'b0, 7'd20, 22'h040000, 1'b0, 0);
    run_op("tie_even", 1'b0, 7'd15, 22'h100200, 1'b0, 0);
    run_op("tie_odd", 1'b0, 7'd15, 22'h100600, 1'b0, 0);
    run_op("carry", 1'b1, 7'd15, 22'h1FFE00, 1'b0, 0);
    run_op("ovf", 1'b0, 7'd31, 22'h100000, 1'b0, 0);
    run_op("ovf_neg", 1'b1, 7'd30, 22'h200000, 1'b0, 0);
    run_op("unf", 1'b0, 7'd0, 22'h100000, 1'b0, 0);
    run_op("unf_negexp", 1'b1, 7'h7C, 22'h180000, 1'b0, 0);
    run_op("shift20", 1'b0, 7'd40, 22'h000001, 1'b0, 0);
    run_op("stall4", 1'b1, 7'd17, 22'h2AB3C7, 1'b0, 4);

    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 7'd40;
    in_mant  = 22'h000001;
    in_zero  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", 32'(out_valid), 32'd0);
    check("midrst:in_ready", 32'(in_ready), 32'd0);
    check("midrst:state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      check("midrst:no_stale", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", 1'b0, 7'd15, 22'h240000, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      rs   = 1'($urandom);
      re   = 7'($urandom);
      p    = $urandom_range(0, 21);
      lead = 22'h1;
      lead = lead << p;
      mask = lead - 22'h1;
      rm   = (22'($urandom) & mask) | lead;
      rz   = ($urandom_range(0, 9) == 0);
      run_op($sformatf("rand%0d", n), rs, re, rm, rz, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/half_norm_round.md
HALF_NORM_ROUND -- requirements
Module: half_norm_round

Interface
REQ-001 SHALL have parameter SHIFT_LIMIT, default 21: maximum left-normalization shifts per operation.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream raw product valid.
REQ-005 SHALL have port in_ready  output  1  block can accept; high only in IDLE; low while rst_n is low.
REQ-006 SHALL have port in_sign  input  1  product sign, sign_a XOR sign_b.
REQ-007 SHALL have port in_exp  input  7  signed biased exponent, exp_a+exp_b-15.
REQ-008 SHALL have port in_mant  input  22  product of 11-bit significands (hidden bit included); binary point between bits 20 and 19.
REQ-009 SHALL have port in_zero  input  1  either operand is zero.
REQ-010 SHALL have port out_valid  output  1  result valid; held until accepted.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_result  output  16  packed IEEE half {sign, exp[4:0], frac[9:0]}.
REQ-013 SHALL have port out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-014 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-015 SHALL capture inputs on an edge where in_valid&&in_ready, as follows:
- exponent is sign-extended to a 9-bit internal exponent;
- next state is DONE if in_zero or in_mant==0, otherwise NORM.
REQ-016 SHALL evaluate NORM once per cycle, as follows:
- if mant[21]=1: shift right 1, OR the shifted-out bit into sticky, exp+1, go to ROUND;
- else if mant[20]=1: go to ROUND;
- else: shift left 1, exp-1, stay in NORM.
REQ-017 SHALL stop at SHIFT_LIMIT left shifts and go to ROUND.
REQ-018 SHALL round in ROUND to nearest-even, as follows:
- kept bits: mant[20:10];
- guard: mant[9];
- sticky: OR(mant[8:0]) | sticky.
- round up when guard&&(sticky||mant[10]).
- inexact = guard|sticky.
REQ-019 SHALL handle a rounding carry out of bit 20 by setting the significand to 1.0 and incrementing exp.
REQ-020 SHALL give overflow when final exp>=31, as follows:
- out_result = {sign, 16'h7C00[14:0]};
- overflow=1, inexact=1.
REQ-021 SHALL give underflow when final exp<=0, as follows:
- out_result = {sign, 15'b0}, flushed to zero (no subnormal output);
- underflow=1, inexact=1.
REQ-022 SHALL output zero for zero input as {in_sign, 15'b0} with all flags 0.
REQ-023 SHALL register out_result/out_flags on entry to DONE; out_valid=1 in DONE.
REQ-024 SHALL return DONE to IDLE on out_valid&&out_ready; out_result/out_flags SHALL stay stable while out_valid&&!out_ready.
REQ-025 SHALL have latency from the accept edge to out_valid of:
- zero input: 1 cycle;
- mant[21:20]!=00: 3 cycles;
- otherwise: 3+n cycles, where n is the number of left shifts.
REQ-026 SHALL accept no new input until the cycle after the output handshake, because in_ready=0 outside IDLE.

Reset
REQ-027 SHALL, while rst_n=0, force the following: state=IDLE, out_valid=0, out_result=16'h0000, out_flags=3'b000, internal registers cleared, in_ready=0.
REQ-028 SHALL discard in-flight data when reset is asserted mid-operation; no output is produced for it after reset.

Configuration
REQ-029 SHALL, with HALF_NR_SAT_EN defined, saturate overflow to {sign, 15'h7BFF}, with overflow=1 and inexact=1.
REQ-030 SHALL, without HALF_NR_SAT_EN, produce ±infinity per REQ-020.

Structure
REQ-031 SHALL place in package half_fp_pkg: HALF_BIAS=15, HALF_EXP_MAX=31, HALF_INF=16'h7C00, HALF_MAXF=16'h7BFF, the FSM state enum and the flag bit indices.
REQ-032 SHALL implement RNE rounding in combinational sub-module half_rne_round, instanced once.

Verification
REQ-033 SHALL cover: in_mant=22'h240000, in_exp=15, sign 0 (1.5*1.5) -> out_result=16'h4080, flags 000, out_valid 3 cycles after accept.
REQ-034 SHALL cover: in_zero=1, in_sign=1 -> out_result=16'h8000, flags 000, latency 1; and in_mant=22'h040000, in_exp=20 -> 2 shifts, out_result=16'h4800, latency 5.
REQ-035 SHALL cover RNE ties: in_mant=22'h100200, in_exp=15 -> 16'h3C00, inexact=1; in_mant=22'h100600 -> 16'h3C02, inexact=1.
REQ-036 SHALL cover: in_mant=22'h100000, in_exp=31 -> 16'h7C00, flags 101 (16'h7BFF with HALF_NR_SAT_EN); in_exp=0 -> 16'h0000, flags 011.
REQ-037 SHALL cover: out_ready held low 4 cycles -> out_result/out_valid stable, in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-038 SHALL cover: rst_n pulsed low during NORM -> out_valid=0 and state IDLE immediately; no stale output after release.
